cpu_boot_loader: RTL

Sequences start-up of the Forth CPU core: holds the CPU in reset, receives a program image as a byte stream over a valid/ready handshake, packs bytes into 16-bit instructions, and writes them to instruction memory. It then releases the CPU so execution starts at address 0. It sits between the host byte link (UART receiver) and the instruction RAM / `cpu` reset input.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/loader_byte_packer.sv | 40 ++++
 rtl/cpu_boot_loader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU boot loader: state encoding, memory depth and image byte order.
// Optional macro CPU_LOADER_CHECKSUM_EN (used by the loader files) adds a trailing XOR checksum byte.
package cpu_pkg;

  localparam int CPU_IMEM_AW = 10;
  localparam int IMEM_DEPTH  = 2 ** CPU_IMEM_AW;

  localparam int BYTE_W      = 8;
  localparam int WORD_W      = 2 * BYTE_W;
  // Image is big-endian: the high byte of every 16-bit field arrives first.
  localparam int HI_BYTE_LSB = BYTE_W;
  localparam int LO_BYTE_LSB = 0;

  typedef enum logic [2:0] {
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } loader_state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// Latches the high byte of a 16-bit field and presents the assembled word alongside the low byte.
// With CPU_LOADER_CHECKSUM_EN defined it also keeps the running XOR of every accepted byte.
module loader_byte_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              take_hi,
`ifdef CPU_LOADER_CHECKSUM_EN
  input  logic              byte_fire,
  input  logic              clear,
  output logic [BYTE_W-1:0] chk,
`endif
  output logic [WORD_W-1:0] word
);

  logic [BYTE_W-1:0] hi;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi <= '0;
    end else if (take_hi) begin
      hi <= in_data;
    end
  end

  assign word = (WORD_W'(hi) << HI_BYTE_LSB) | (WORD_W'(in_data) << LO_BYTE_LSB);

`ifdef CPU_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      chk <= '0;
    end else if (byte_fire) begin
      chk <= chk ^ in_data;
    end
  end
`endif

endmodule

// File: rtl/cpu_boot_loader.sv
// Boot loader: holds the CPU in reset, streams a length-prefixed image into instruction RAM, then releases it.
// Optional macro CPU_LOADER_CHECKSUM_EN: a trailing XOR checksum byte must match before the CPU is released.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_LEN_HI  | waiting for high byte of word count
// ST_LEN_LO  | waiting for low byte of word count; range-checked here
// ST_DATA_HI | waiting for high byte of next instruction word
// ST_DATA_LO | waiting for low byte; word is written to RAM
// ST_CHECK   | waiting for checksum byte (checksum builds only)
// ST_RUN     | image loaded, CPU released
// ST_ERROR   | load failed, CPU held in reset until boot
module cpu_boot_loader
  import cpu_pkg::*;
#(
  parameter int IMEM_AW = CPU_IMEM_AW,
  parameter int IMEM_DW = WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               boot,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [IMEM_DW-1:0] imem_wdata,
  output logic               imem_we,
  output logic               cpu_reset,
  output logic               done,
  output logic               error
);

  localparam int DEPTH = 2 ** IMEM_AW;

  loader_state_t     state;
  logic [IMEM_AW:0]  words_left;
  logic [WORD_W-1:0] word;
  logic              fire;
  logic              take_hi;

  assign fire    = in_valid && in_ready;
  assign take_hi = fire && (state == ST_LEN_HI || state == ST_DATA_HI);

`ifdef CPU_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] chk;
  logic              clear;

  assign clear = boot && (state == ST_RUN || state == ST_ERROR);

  loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .take_hi   (take_hi),
    .byte_fire (fire),
    .clear     (clear),
    .chk       (chk),
    .word      (word)
  );
`else
  loader_byte_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .take_hi (take_hi),
    .word    (word)
  );
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_LEN_HI;
      in_ready   <= 1'b0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      words_left <= '0;
    end else begin
      imem_we <= 1'b0;
      // Address advances in the cycle after each write so it is stable during the strobe.
      if (imem_we) imem_addr <= imem_addr + IMEM_AW'(1);

      case (state)
        ST_LEN_HI: begin
          in_ready <= 1'b1;
          if (fire) state <= ST_LEN_LO;
        end

        ST_LEN_LO: begin
          if (fire) begin
            if (word == '0 || int'(word) > DEPTH) begin
              state    <= ST_ERROR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              words_left <= word[IMEM_AW:0];
              imem_addr  <= '0;
              state      <= ST_DATA_HI;
            end
          end
        end

        ST_DATA_HI: begin
          if (fire) state <= ST_DATA_LO;
        end

        ST_DATA_LO: begin
          if (fire) begin
            imem_we    <= 1'b1;
            imem_wdata <= IMEM_DW'(word);
            words_left <= words_left - (IMEM_AW + 1)'(1);
            if (words_left == (IMEM_AW + 1)'(1)) begin
`ifdef CPU_LOADER_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state     <= ST_RUN;
              in_ready  <= 1'b0;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
`endif
            end else begin
              state <= ST_DATA_HI;
            end
          end
        end

`ifdef CPU_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (fire) begin
            in_ready <= 1'b0;
            if (in_data == chk) begin
              state     <= ST_RUN;
              cpu_reset <= 1'b0;
              done      <= 1'b1;
            end else begin
              state <= ST_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif

        ST_RUN, ST_ERROR: begin
          if (boot) begin
            state     <= ST_LEN_HI;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
          end
        end

        default: begin
          state    <= ST_ERROR;
          error    <= 1'b1;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
